psddivide_seq: RTL and testbench

Operand sequencer that sits directly upstream of the sequential non-restoring divider, psddivide. It accepts 32-bit dividend/divisor pairs on a valid/ready handshake and drives the divider's start/stop protocol with exact cycle timing. It captures quotient and rest and presents them on a valid/ready result port. Divide-by-zero is trapped locally and never reaches the divider.

---
 rtl/psddivide_pkg.sv | 24 ++
 rtl/psddivide_seq_if.sv | 46 ++++
 rtl/psddivide_seq.sv | 133 +++++++++++++
 tb/tb_psddivide_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psddivide_pkg.sv
// Shared definitions for the psddivide operand sequencer: default sizing,
// FSM state encoding and the quotient pattern reported for a zero divisor.
package psddivide_pkg;

    // Default operand/result width.
    localparam int unsigned DEF_WIDTH      = 32;
    // Default divider execution time, counted from the cycle start is
    // sampled to the cycle stop is driven.
    localparam int unsigned DEF_DIV_CYCLES = 32;

    // Sequencer states; IDLE is the only state that accepts operands.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StWait    = 3'd2,
        StStop    = 3'd3,
        StCapture = 3'd4,
        StResult  = 3'd5
    } state_t;

    // Quotient reported when the divisor is zero: every bit set.
    localparam logic [DEF_WIDTH-1:0] DIVZERO_QUOTIENT = '1;

endpackage

// File: rtl/psddivide_seq_if.sv
// Operand and result handshake bundle between a producer/consumer and the
// psddivide sequencer. The sequencer takes the slave view.
interface psddivide_seq_if
    import psddivide_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_rest;
    logic             out_divzero;

    modport slave (
        input  in_valid,
        input  in_dividend,
        input  in_divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_quotient,
        output out_rest,
        output out_divzero
    );

    modport master (
        output in_valid,
        output in_dividend,
        output in_divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_quotient,
        input  out_rest,
        input  out_divzero
    );

endinterface

// File: rtl/psddivide_seq.sv
// Operand sequencer for the non-restoring divider psddivide. Accepts one
// dividend/divisor pair at a time, drives the divider's start/stop pulses
// with fixed timing, captures quotient/rest and offers them as a result.
// A zero divisor is answered locally and never starts the divider.
// Every output is a register or a decode of the state register, so nothing
// combinationally depends on in_valid or out_ready.
module psddivide_seq
    import psddivide_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    psddivide_seq_if.slave   io,
    output logic             div_start,
    output logic             div_stop,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_rest,
    output logic             busy
);

    // Wide enough to hold DIV_CYCLES, so the count never wraps mid-operation.
    localparam int unsigned   CntW    = $clog2(DIV_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_t           state_q,    state_d;
    logic [CntW-1:0]  cnt_q,      cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q,  divisor_d;
    logic [WIDTH-1:0] quot_q,     quot_d;
    logic [WIDTH-1:0] rest_q,     rest_d;
    logic             divzero_q,  divzero_d;

    // State and datapath registers; reset clears everything at once and
    // drops any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rest_q     <= '0;
            divzero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rest_q     <= rest_d;
            divzero_q  <= divzero_d;
        end
    end

    // Next-state and datapath update for the operation sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rest_d     = rest_q;
        divzero_d  = divzero_q;

        unique case (state_q)
            StIdle: begin
                // in_ready is high throughout IDLE, so in_valid is the handshake.
                if (io.in_valid) begin
                    dividend_d = io.in_dividend;
                    divisor_d  = io.in_divisor;
                    if (io.in_divisor == '0) begin
                        quot_d    = {WIDTH{DIVZERO_QUOTIENT[0]}};
                        rest_d    = io.in_dividend;
                        divzero_d = 1'b1;
                        state_d   = StResult;
                    end else begin
                        state_d   = StStart;
                    end
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Leave after DIV_CYCLES cycles in this state.
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                state_d = StCapture;
            end
            StCapture: begin
                // The divider sampled stop on the previous edge; its outputs
                // are final now.
                quot_d    = div_quotient;
                rest_d    = div_rest;
                divzero_d = 1'b0;
                state_d   = StResult;
            end
            StResult: begin
                if (io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and divider control decoded from the state register only.
    assign io.in_ready  = (state_q == StIdle);
    assign io.out_valid = (state_q == StResult);
    assign div_start    = (state_q == StStart);
    assign div_stop     = (state_q == StStop);
    assign busy         = (state_q != StIdle);

    // Registered data outputs.
    assign io.out_quotient = quot_q;
    assign io.out_rest     = rest_q;
    assign io.out_divzero  = divzero_q;
    assign div_dividend    = dividend_q;
    assign div_divisor     = divisor_q;

endmodule

// File: tb/tb_psddivide_seq.sv
// Self-checking bench for psddivide_seq with a behavioural psddivide beside it.
// Expected results go into a scoreboard queue at issue time; a monitor pops
// and compares on every result handshake.
module tb_psddivide_seq;
    import psddivide_pkg::*;

    localparam int unsigned W = DEF_WIDTH;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         div_start, div_stop, busy;
    logic [W-1:0] div_dividend, div_divisor, div_quotient, div_rest;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;
    int   start_count = 0;
    int   start_rise  = 0;
    int   stop_rise   = 0;
    logic prev_start  = 1'b0;
    logic prev_stop   = 1'b0;
    exp_t sb[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    psddivide_seq_if #(.WIDTH(W)) io ();

    psddivide_seq #(
        .WIDTH      (W),
        .DIV_CYCLES (DEF_DIV_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io           (io.slave),
        .div_start    (div_start),
        .div_stop     (div_stop),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_rest     (div_rest),
        .busy         (busy)
    );

    // Divider stand-in: junk while running, final values once stop is sampled.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_quotient <= '0;
            div_rest     <= '0;
        end else if (div_start) begin
            div_quotient <= 32'h5a5a_5a5a;
            div_rest     <= 32'ha5a5_a5a5;
        end else if (div_stop && div_divisor != '0) begin
            div_quotient <= div_dividend / div_divisor;
            div_rest     <= div_dividend % div_divisor;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Result monitor: compare on every handshake.
    always @(negedge clock) begin
        exp_t e;
        if (reset && io.out_valid && io.out_ready) begin
            hs_cyc = cyc + 1;
            if (sb.size() == 0) begin
                check("unexpected result", 64'(io.out_quotient), 64'(32'hbad));
            end else begin
                e = sb.pop_front();
                check("quotient", 64'(io.out_quotient), 64'(e.q));
                check("rest", 64'(io.out_rest), 64'(e.r));
                check("divzero", 64'(io.out_divzero), 64'(e.dz));
            end
        end
    end

    // Divider-control timing monitor.
    always @(negedge clock) begin
        if (div_start && !prev_start) begin
            start_rise = cyc;
            start_count++;
        end
        if (!div_start && prev_start) check("div_start width", 64'(cyc - start_rise), 64'(1));
        if (div_stop && !prev_stop) begin
            stop_rise = cyc;
            check("start to stop distance", 64'(cyc - start_rise), 64'(DEF_DIV_CYCLES + 1));
        end
        if (!div_stop && prev_stop) check("div_stop width", 64'(cyc - stop_rise), 64'(1));
        prev_start = div_start;
        prev_stop  = div_stop;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
        int n;
        io.in_valid    = 1'b1;
        io.in_dividend = a;
        io.in_divisor  = b;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!io.in_ready && n < 500);
        if (!io.in_ready) check("in_ready timeout", 64'(io.in_ready), 64'(1));
        @(posedge clock);
        #1;
        acc = cyc;
    endtask

    task automatic wait_valid(output int seen);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!io.out_valid && n < 200);
        if (!io.out_valid) check("out_valid timeout", 64'(io.out_valid), 64'(1));
        seen = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   acc, acc_b, seen, sc;
        logic stable;
        logic [31:0] a, b;

        io.in_valid    = 1'b0;
        io.in_dividend = '0;
        io.in_divisor  = '0;
        io.out_ready   = 1'b0;

        // Reset state
        #12;
        check("reset in_ready", 64'(io.in_ready), 64'(1));
        check("reset out_valid", 64'(io.out_valid), 64'(0));
        check("reset start/stop/busy", 64'({div_start, div_stop, busy}), 64'(0));
        check("reset out data", 64'({io.out_quotient, io.out_rest}), 64'(0));
        check("reset div operands", 64'({div_dividend, div_divisor}), 64'(0));
        check("reset divzero", 64'(io.out_divzero), 64'(0));
        #11 reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: normal divide, pulse timing and latency
        io.out_ready = 1'b1;
        sb.push_back('{q: 32'h0000_0001, r: 32'h0645_57be, dz: 1'b0});
        send(32'h1234_5678, 32'h0bee_feba, acc);
        io.in_valid    = 1'b0;
        io.in_dividend = 32'hffff_ffff;
        io.in_divisor  = 32'h0000_0001;
        repeat (5) @(negedge clock);
        check("div_dividend held", 64'(div_dividend), 64'(32'h1234_5678));
        check("div_divisor held", 64'(div_divisor), 64'(32'h0bee_feba));
        check("busy while running", 64'(busy), 64'(1));
        check("in_ready low while running", 64'(io.in_ready), 64'(0));
        wait_valid(seen);
        check("normal latency", 64'(seen - acc), 64'(DEF_DIV_CYCLES + 3));
        @(posedge clock);
        #1;

        // 2: back-to-back with in_valid held high
        sb.push_back('{q: 32'h0, r: 32'h0, dz: 1'b0});
        send(32'h0000_0000, 32'h0bee_feba, acc);
        sb.push_back('{q: 32'h1, r: 32'h0, dz: 1'b0});
        send(32'h0000_0001, 32'h0000_0001, acc_b);
        check("accept one cycle after result handshake", 64'(acc_b - hs_cyc), 64'(1));
        io.in_valid = 1'b0;
        wait_valid(seen);
        @(posedge clock);
        #1;

        // 3: zero divisor trapped locally
        sc = start_count;
        sb.push_back('{q: 32'hffff_ffff, r: 32'hdead_beef, dz: 1'b1});
        send(32'hdead_beef, 32'h0000_0000, acc);
        io.in_valid = 1'b0;
        @(negedge clock);
        check("divzero out_valid next cycle", 64'(io.out_valid), 64'(1));
        @(posedge clock);
        #1;
        check("no div_start on zero divisor", 64'(start_count), 64'(sc));

        // 4: consumer stall for 20 cycles
        io.out_ready = 1'b0;
        sb.push_back('{q: 32'd14, r: 32'd2, dz: 1'b0});
        send(32'd100, 32'd7, acc);
        io.in_valid = 1'b0;
        wait_valid(seen);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (io.out_valid !== 1'b1 || io.out_quotient !== 32'd14 || io.out_rest !== 32'd2 ||
                io.out_divzero !== 1'b0 || io.in_ready !== 1'b0) stable = 1'b0;
        end
        check("stall outputs stable", 64'(stable), 64'(1));
        @(posedge clock);
        #1;
        io.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("consumed on first ready cycle", 64'({io.out_valid, io.in_ready}), 64'(2'b01));
        @(posedge clock);
        #1;

        // 5: asynchronous reset in the middle of WAIT
        send(32'h0000_0100, 32'h0000_0003, acc);
        io.in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async reset controls", 64'({div_start, div_stop, io.out_valid, busy}), 64'(0));
        check("async reset operands", 64'({div_dividend, div_divisor}), 64'(0));
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        check("in_ready after reset release", 64'(io.in_ready), 64'(1));
        @(posedge clock);
        #1;
        sb.push_back('{q: 32'h0fff_ffff, r: 32'h0000_000f, dz: 1'b0});
        send(32'hffff_ffff, 32'h0000_0010, acc);
        io.in_valid = 1'b0;
        wait_valid(seen);
        @(posedge clock);
        #1;

        // 6: walking ones on dividend and divisor
        for (int i = 0; i < 32; i++) begin
            a = 32'h1 << i;
            b = 32'h1 << (31 - i);
            sb.push_back('{q: a / b, r: a % b, dz: 1'b0});
            send(a, b, acc);
            io.in_valid = 1'b0;
            wait_valid(seen);
            @(posedge clock);
            #1;
            a = ~(32'h1 << i);
            b = 32'h1 << i;
            sb.push_back('{q: a / b, r: a % b, dz: 1'b0});
            send(a, b, acc);
            io.in_valid = 1'b0;
            wait_valid(seen);
            @(posedge clock);
            #1;
        end

        repeat (3) @(negedge clock);
        check("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
